decode_rf_fwd_stage: RTL
========================

Name: decode_rf_fwd_stage

Overview:
- Parametrised successor to the single-source decode/RF-read stage of the 16-bit pipelined CPU; sits between fetch (IF) and execute (EX).
- Decodes the instruction, drives register-file read addresses, and selects operands from N prioritised forwarding sources (EX/MEM/WB).
- Sign-extends the immediates and registers the result into the ID/EX pipeline register.
- Adds three behaviours: load-use hazard detection with bubble insertion, downstream stall hold, and flush. Also keeps a saturating stall counter.

Parameters:
- DATA_W, 16, operand/data width; immediates sign-extend to DATA_W.
- NFWD, 3, number of forwarding sources; index 0 = youngest = highest priority.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  IF/ID holds a valid instruction.
- i_pc  in  16  PC of the instruction.
- i_instr  in  16  instruction word.
- o_rf_raddr1  out  3  RF read address, Rx = instr[7:5], combinational.
- o_rf_raddr2  out  3  RF read address, Ry = instr[10:8], combinational.
- i_rf_rdata1  in  DATA_W  RF data for Rx.
- i_rf_rdata2  in  DATA_W  RF data for Ry.
- i_fwd_valid  in  NFWD  forwarding source i writes a register.
- i_fwd_reg  in  NFWD*3  destination register of source i.
- i_fwd_data  in  NFWD*DATA_W  result of source i.
- i_ex_stall  in  1  EX cannot accept; hold ID/EX.
- i_flush  in  1  taken branch/jump; kill ID/EX contents.
- o_if_stall  out  1  combinational; IF/ID must hold.
- o_valid  out  1  ID/EX valid.
- o_pc  out  16  ID/EX PC.
- o_instr  out  16  ID/EX instruction.
- o_rx  out  3  ID/EX Rx field.
- o_ry  out  3  ID/EX Ry field.
- o_rx_valid  out  1  ID/EX Rx operand used.
- o_ry_valid  out  1  ID/EX Ry operand used.
- o_opA  out  DATA_W  ID/EX operand A.
- o_opB  out  DATA_W  ID/EX operand B.
- o_imm8  out  DATA_W  sext(instr[15:8]).
- o_imm11  out  DATA_W  sext(instr[15:5]).
- o_stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: every registered output is 0, including o_valid and o_stall_cnt. Reset asserted mid-operation discards the in-flight instruction.
- Decode, opcode = instr[4:0]:
  - rx_valid when opcode matches x00xx, 0010x, 10110, 0100x, 01010 or 01100.
  - ry_valid when opcode matches 000xx or 0010x.
  - A load is opcode == OP_LD (5'b00100); its destination is its Rx field.
- Forwarding, per operand:
  - Operand A: the lowest index i with i_fwd_valid[i] && i_fwd_reg[i]==Rx && rx_valid supplies i_fwd_data[i]; if none matches, i_rf_rdata1. Operand B is the same with Ry / i_rf_rdata2.
  - Unused operands pass RF data unmodified, so an invalid or unused field never forwards.
- Load-use hazard: haz = i_valid && o_valid && o_instr is OP_LD && ((rx_valid && Rx==o_rx) || (ry_valid && Ry==o_rx)).
- Update priority each cycle, first match wins:
  1. i_flush: o_valid<=0; other fields unchanged.
  2. i_ex_stall: hold all ID/EX fields.
  3. haz: o_valid<=0 (bubble); other fields unchanged.
  4. Otherwise load all fields, with o_valid<=i_valid.
- o_if_stall = !i_flush && (i_ex_stall || haz).
- A hazard always costs exactly one bubble cycle. Next cycle the load sits in MEM, and its forwarding source supplies the data.
- o_stall_cnt increments on each cycle with o_if_stall=1 and saturates at all-ones without wrapping.
- Latency: one cycle from IF/ID to ID/EX.

Decomposition:
- definesPkg holds:
  - opcode constants (OP_LD) and the casex match classes as functions is_rx_used / is_ry_used;
  - field-position localparams;
  - a packed id_ex_t struct that is parametrised by DATA_W via the package default.
- One natural sub-module: fwd_mux (NFWD-way priority operand select), instantiated twice.

Test Plan:
- Reset mid-stream, then release with i_valid=1, instr=add R1,R2 -> o_valid=0 and all outputs 0 during reset; next edge o_valid=1 and o_rx=1.
- Forward priority: Rx=3, fwd0=(1,R3,0x1111), fwd2=(1,R3,0x3333), rdata1=0xAAAA -> o_opA=0x1111. Then drop fwd0 -> 0x3333.
- Unused operand: opcode with ry_valid=0, Ry=3, fwd0=(1,R3,0x5555), rdata2=0x0042 -> o_opB=0x0042.
- Load-use: ld R4 issued, then an instruction reading Ry=4 -> one cycle with o_if_stall=1 and o_valid=0. Next cycle, with fwd1=(1,R4,0xBEEF), the instruction issues with o_opB=0xBEEF and o_stall_cnt=1.
- Simultaneous i_flush and i_ex_stall -> o_valid=0 next edge, o_if_stall=0, counter unchanged.
- Saturation with CNT_W=4: 20 cycles of i_ex_stall -> o_stall_cnt=15 and held there.

Source files
------------

// File: rtl/decode_rf_fwd_stage_pkg.sv
// Shared decode definitions for the ID stage: opcode constants, field positions,
// operand-use classes and the ID/EX pipeline record.
package definesPkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned REG_W      = 3;

    localparam int unsigned OPC_LSB   = 0;
    localparam int unsigned OPC_MSB   = 4;
    localparam int unsigned RX_LSB    = 5;
    localparam int unsigned RX_MSB    = 7;
    localparam int unsigned RY_LSB    = 8;
    localparam int unsigned RY_MSB    = 10;
    localparam int unsigned IMM8_LSB  = 8;
    localparam int unsigned IMM11_LSB = 5;

    localparam logic [4:0] OP_LD = 5'b00100;

    typedef struct packed {
        logic                  valid;
        logic [INSTR_W-1:0]    pc;
        logic [INSTR_W-1:0]    instr;
        logic [REG_W-1:0]      rx;
        logic [REG_W-1:0]      ry;
        logic                  rx_valid;
        logic                  ry_valid;
        logic [DEF_DATA_W-1:0] opA;
        logic [DEF_DATA_W-1:0] opB;
        logic [DEF_DATA_W-1:0] imm8;
        logic [DEF_DATA_W-1:0] imm11;
    } id_ex_t;

    function automatic logic is_rx_used(input logic [4:0] op);
        logic used;
        used = 1'b0;
        casez (op)
            5'b?00??, 5'b0010?, 5'b10110,
            5'b0100?, 5'b01010, 5'b01100: used = 1'b1;
            default:                      used = 1'b0;
        endcase
        return used;
    endfunction

    function automatic logic is_ry_used(input logic [4:0] op);
        logic used;
        used = 1'b0;
        casez (op)
            5'b000??, 5'b0010?: used = 1'b1;
            default:            used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/decode_rf_fwd_stage_fwd_mux.sv
// Priority operand select: the lowest-index forwarding source writing the
// requested register wins, otherwise the register-file value passes through.
module fwd_mux #(
    parameter int unsigned NFWD   = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic                   en,
    input  logic [2:0]             sel_reg,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*3-1:0]      fwd_reg,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic [DATA_W-1:0]      rf_data,
    output logic [DATA_W-1:0]      operand
);

    logic found;

    always_comb begin
        operand = rf_data;
        found   = 1'b0;
        for (int unsigned i = 0; i < NFWD; i++) begin
            if (!found && en && fwd_valid[i] && (fwd_reg[i*3 +: 3] == sel_reg)) begin
                operand = fwd_data[i*DATA_W +: DATA_W];
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_rf_fwd_stage.sv
// Decode / register-read stage: decodes operands, forwards from NFWD sources,
// detects load-use hazards and registers the result into ID/EX.
module decode_rf_fwd_stage
    import definesPkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NFWD   = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [15:0]            i_pc,
    input  logic [15:0]            i_instr,
    output logic [2:0]             o_rf_raddr1,
    output logic [2:0]             o_rf_raddr2,
    input  logic [DATA_W-1:0]      i_rf_rdata1,
    input  logic [DATA_W-1:0]      i_rf_rdata2,
    input  logic [NFWD-1:0]        i_fwd_valid,
    input  logic [NFWD*3-1:0]      i_fwd_reg,
    input  logic [NFWD*DATA_W-1:0] i_fwd_data,
    input  logic                   i_ex_stall,
    input  logic                   i_flush,
    output logic                   o_if_stall,
    output logic                   o_valid,
    output logic [15:0]            o_pc,
    output logic [15:0]            o_instr,
    output logic [2:0]             o_rx,
    output logic [2:0]             o_ry,
    output logic                   o_rx_valid,
    output logic                   o_ry_valid,
    output logic [DATA_W-1:0]      o_opA,
    output logic [DATA_W-1:0]      o_opB,
    output logic [DATA_W-1:0]      o_imm8,
    output logic [DATA_W-1:0]      o_imm11,
    output logic [CNT_W-1:0]       o_stall_cnt
);

    // Same layout as id_ex_t, but sized by this instance's DATA_W rather than the package default.
    typedef struct packed {
        logic               valid;
        logic [15:0]        pc;
        logic [15:0]        instr;
        logic [2:0]         rx;
        logic [2:0]         ry;
        logic               rx_valid;
        logic               ry_valid;
        logic [DATA_W-1:0]  opA;
        logic [DATA_W-1:0]  opB;
        logic [DATA_W-1:0]  imm8;
        logic [DATA_W-1:0]  imm11;
    } stage_t;

    stage_t             q;
    stage_t             d;
    logic [4:0]         opcode;
    logic [2:0]         rx;
    logic [2:0]         ry;
    logic               rx_used;
    logic               ry_used;
    logic               ld_in_ex;
    logic               haz;
    logic [DATA_W-1:0]  opA_sel;
    logic [DATA_W-1:0]  opB_sel;
    logic [CNT_W-1:0]   stall_cnt;

    assign opcode  = i_instr[OPC_MSB:OPC_LSB];
    assign rx      = i_instr[RX_MSB:RX_LSB];
    assign ry      = i_instr[RY_MSB:RY_LSB];
    assign rx_used = is_rx_used(opcode);
    assign ry_used = is_ry_used(opcode);

    assign o_rf_raddr1 = rx;
    assign o_rf_raddr2 = ry;

    fwd_mux #(.NFWD(NFWD), .DATA_W(DATA_W)) u_fwd_a (
        .en        (rx_used),
        .sel_reg   (rx),
        .fwd_valid (i_fwd_valid),
        .fwd_reg   (i_fwd_reg),
        .fwd_data  (i_fwd_data),
        .rf_data   (i_rf_rdata1),
        .operand   (opA_sel)
    );

    fwd_mux #(.NFWD(NFWD), .DATA_W(DATA_W)) u_fwd_b (
        .en        (ry_used),
        .sel_reg   (ry),
        .fwd_valid (i_fwd_valid),
        .fwd_reg   (i_fwd_reg),
        .fwd_data  (i_fwd_data),
        .rf_data   (i_rf_rdata2),
        .operand   (opB_sel)
    );

    // A load sitting in ID/EX cannot forward yet; its destination is its Rx field.
    assign ld_in_ex   = q.valid && (q.instr[OPC_MSB:OPC_LSB] == OP_LD);
    assign haz        = i_valid && ld_in_ex &&
                        ((rx_used && (rx == q.rx)) || (ry_used && (ry == q.rx)));
    assign o_if_stall = !i_flush && (i_ex_stall || haz);

    always_comb begin
        d          = '0;
        d.valid    = i_valid;
        d.pc       = i_pc;
        d.instr    = i_instr;
        d.rx       = rx;
        d.ry       = ry;
        d.rx_valid = rx_used;
        d.ry_valid = ry_used;
        d.opA      = opA_sel;
        d.opB      = opB_sel;
        d.imm8     = {{(DATA_W-8){i_instr[15]}}, i_instr[15:IMM8_LSB]};
        d.imm11    = {{(DATA_W-11){i_instr[15]}}, i_instr[15:IMM11_LSB]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            stall_cnt <= '0;
        end else begin
            if (i_flush) begin
                q.valid <= 1'b0;
            end else if (!i_ex_stall) begin
                if (haz) begin
                    q.valid <= 1'b0;
                end else begin
                    q <= d;
                end
            end
            if (o_if_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_valid     = q.valid;
    assign o_pc        = q.pc;
    assign o_instr     = q.instr;
    assign o_rx        = q.rx;
    assign o_ry        = q.ry;
    assign o_rx_valid  = q.rx_valid;
    assign o_ry_valid  = q.ry_valid;
    assign o_opA       = q.opA;
    assign o_opB       = q.opB;
    assign o_imm8      = q.imm8;
    assign o_imm11     = q.imm11;
    assign o_stall_cnt = stall_cnt;

endmodule
